// File: rtl/cache_pkg.sv
// Shared encodings for the cache-side valid/tag memories.
// State and read-source enums are used by ram_1w2r_clr.
package cache_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;
  typedef enum logic [1:0] {RS_ZERO = 2'd0, RS_BANK = 2'd1, RS_FWD = 2'd2} rsel_e;
endpackage

// File: rtl/ram_1w1r.sv
// One 1-write/1-read bank with a registered read port and an unreset array,
// so it maps onto a block RAM primitive.
module ram_1w1r #(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [DEEPTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [DEEPTH-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [2**DEEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_1w2r_clr.sv
// Two lockstep-written banks give two independent read ports; a sweep FSM
// zeroes every word after reset or on clr_req, with write-first forwarding.
module ram_1w2r_clr
  import cache_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEEPTH-1:0] W_addr,
  input  logic [WIDTH-1:0]  W_data,
  input  logic              W_en,
  input  logic [DEEPTH-1:0] R_addr_A,
  input  logic              R_en_A,
  output logic [WIDTH-1:0]  R_data_A,
  input  logic [DEEPTH-1:0] R_addr_B,
  input  logic              R_en_B,
  output logic [WIDTH-1:0]  R_data_B,
  input  logic              clr_req,
  output logic              busy
);
  localparam logic [DEEPTH-1:0] PTR_MAX = '1;

  state_e            r_state, w_state_nx;
  logic [DEEPTH-1:0] r_ptr;
  logic              w_wr_ok, w_we;
  logic [DEEPTH-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;

  logic [1:0][DEEPTH-1:0] w_raddr;
  logic [1:0]             w_ren;
  logic [1:0][WIDTH-1:0]  w_rdata;

  assign w_raddr = {R_addr_B, R_addr_A};
  assign w_ren   = {R_en_B, R_en_A};

  // Clear wins over a same-cycle external write.
  assign w_wr_ok = (r_state == ST_READY) && W_en && !clr_req && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    r_ptr <= '0;
    else if (r_state == ST_CLEAR)               r_ptr <= r_ptr + 1'b1;
    else if (clr_req)                           r_ptr <= '0;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_CLEAR: if (r_ptr == PTR_MAX) w_state_nx = ST_READY;
      ST_READY: if (clr_req)          w_state_nx = ST_CLEAR;
      default:                        w_state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy    = (r_state == ST_CLEAR);
    w_we    = 1'b0;
    w_waddr = W_addr;
    w_wdata = W_data;
    if (!rst && r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = '0;
    end else if (w_wr_ok) begin
      w_we    = 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    rsel_e            r_sel;
    logic [WIDTH-1:0] r_fwd;
    logic [WIDTH-1:0] w_bank_q;
    logic             w_fwd;

    assign w_fwd = w_wr_ok && w_ren[g] && (W_addr == w_raddr[g]);

    ram_1w1r #(.WIDTH(WIDTH), .DEEPTH(DEEPTH)) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_ren[g] && !busy && !w_fwd && !rst),
      .i_raddr (w_raddr[g]),
      .o_rdata (w_bank_q)
    );

    // Source select decides which holding register drives the port.
    always_ff @(posedge clk) begin
      if (rst)              r_sel <= RS_ZERO;
      else if (w_ren[g]) begin
        if (busy)           r_sel <= RS_ZERO;
        else if (w_fwd)     r_sel <= RS_FWD;
        else                r_sel <= RS_BANK;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && w_fwd) r_fwd <= W_data;
    end

    always_comb begin
      case (r_sel)
        RS_BANK: w_rdata[g] = w_bank_q;
        RS_FWD:  w_rdata[g] = r_fwd;
        default: w_rdata[g] = '0;
      endcase
    end
  end

  assign R_data_A = w_rdata[0];
  assign R_data_B = w_rdata[1];
endmodule

// File: tb/tb_ram_1w2r_clr.sv
// Self-checking bench for ram_1w2r_clr (WIDTH=8, DEEPTH=3): per-cycle vectors
// with hand-derived expectations, output checks queued and popped after the edge.
module tb_ram_1w2r_clr;
  logic       clk = 1'b0;
  logic       rst, W_en, R_en_A, R_en_B, clr_req, busy;
  logic [2:0] W_addr, R_addr_A, R_addr_B;
  logic [7:0] W_data, R_data_A, R_data_B;

  ram_1w2r_clr #(.WIDTH(8), .DEEPTH(3)) dut (
    .clk(clk), .rst(rst), .W_addr(W_addr), .W_data(W_data), .W_en(W_en),
    .R_addr_A(R_addr_A), .R_en_A(R_en_A), .R_data_A(R_data_A),
    .R_addr_B(R_addr_B), .R_en_B(R_en_B), .R_data_B(R_data_B),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, we; logic [2:0] wa; logic [7:0] wd;
    logic rea; logic [2:0] ra; logic reb; logic [2:0] rb; logic clr;
    int busy; int ea; int eb;   // -1: not checked
  } vec_t;
  typedef struct { string nm; int ea; int eb; } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_pass = 0, n_tot = 0;

  function automatic vec_t V(logic r, logic we, int wa, int wd, logic rea, int ra,
                             logic reb, int rb, logic clr, int bz, int ea, int eb);
    vec_t v;
    v.rst = r; v.we = we; v.wa = 3'(wa); v.wd = 8'(wd);
    v.rea = rea; v.ra = 3'(ra); v.reb = reb; v.rb = 3'(rb); v.clr = clr;
    v.busy = bz; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle; busy is checked in-cycle, read data after the edge.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    rst = v.rst; W_en = v.we; W_addr = v.wa; W_data = v.wd;
    R_en_A = v.rea; R_addr_A = v.ra; R_en_B = v.reb; R_addr_B = v.rb; clr_req = v.clr;
    if (v.busy >= 0) chk({nm, "_busy"}, 32'(busy), 32'(v.busy));
    e.nm = nm; e.ea = v.ea; e.eb = v.eb;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (e.ea >= 0) chk({e.nm, "_A"}, 32'(R_data_A), 32'(e.ea));
    if (e.eb >= 0) chk({e.nm, "_B"}, 32'(R_data_B), 32'(e.eb));
  endtask

  task automatic idle(input int bz, input string nm);
    step(V(0,0,0,0, 0,0, 0,0, 0, bz, -1, -1), nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset, sweep length, first read after sweep
    step(V(1,0,0,0, 1,5, 1,5, 0, -1, 0, 0), "t1_rst0");
    step(V(1,0,0,0, 1,5, 1,5, 0,  1, 0, 0), "t1_rst1");
    for (int k = 0; k < 8; k++) idle(1, $sformatf("t1_sweep%0d", k));
    step(V(0,0,0,0, 1,5, 1,5, 0, 0, 0, 0), "t1_rd5");

    // Tests 2-3: table of basic read/write/forward vectors
    tbl.push_back(V(0,1,2,8'h3C, 0,0, 0,0, 0, 0, -1, -1));
    tbl.push_back(V(0,0,0,0,     1,2, 1,2, 0, 0, 8'h3C, 8'h3C));
    tbl.push_back(V(0,0,0,0,     0,0, 0,0, 0, 0, 8'h3C, 8'h3C));
    tbl.push_back(V(0,0,0,0,     0,0, 0,0, 0, 0, 8'h3C, 8'h3C));
    tbl.push_back(V(0,0,0,0,     0,0, 0,0, 0, 0, 8'h3C, 8'h3C));
    tbl.push_back(V(0,1,3,8'h11, 0,0, 0,0, 0, 0, 8'h3C, 8'h3C));
    tbl.push_back(V(0,1,4,8'h55, 1,4, 1,3, 0, 0, 8'h55, 8'h11));
    tbl.push_back(V(0,1,5,8'h66, 1,5, 1,5, 0, 0, 8'h66, 8'h66));
    tbl.push_back(V(0,0,0,0,     1,4, 1,5, 0, 0, 8'h55, 8'h66));
    tbl.push_back(V(0,0,0,0,     0,0, 0,0, 0, 0, 8'h55, 8'h66));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Test 4: fill, clear with dropped write and ignored second clr_req
    for (int i = 0; i < 8; i++)
      step(V(0,1,i,8'hA0+i, i>0,i-1, 0,0, 0, 0, (i>0) ? 8'hA0+i-1 : -1, -1),
           $sformatf("t4_fill%0d", i));
    step(V(0,0,0,0, 1,7, 1,0, 0, 0, 8'hA7, 8'hA0), "t4_rd70");
    step(V(0,0,0,0, 1,3, 1,3, 0, 0, 8'hA3, 8'hA3), "t4_rd33");
    step(V(0,0,0,0, 0,0, 0,0, 1, 0, -1, -1), "t4_clr");
    for (int k = 0; k < 8; k++) begin
      if (k == 2)      step(V(0,0,0,0,     1,7, 0,0, 0, 1, 0, -1), "t4_busyrd");
      else if (k == 3) step(V(0,0,0,0,     0,0, 0,0, 1, 1, -1, -1), "t4_clr2");
      else if (k == 5) step(V(0,1,1,8'hFF, 0,0, 0,0, 0, 1, -1, -1), "t4_busywr");
      else if (k == 7) step(V(0,0,0,0,     1,2, 1,6, 0, 1, 0, 0), "t4_lastrd");
      else idle(1, $sformatf("t4_busy%0d", k));
    end
    step(V(0,0,0,0, 1,1, 1,7, 0, 0, 0, 0), "t4_after");

    // Test 5: write in the clr_req cycle is dropped and not forwarded
    step(V(0,1,6,8'h12, 0,0, 0,0, 0, 0, -1, -1), "t5_wr12");
    step(V(0,1,6,8'h77, 1,6, 0,0, 1, 0, 8'h12, -1), "t5_clrwr");
    for (int k = 0; k < 8; k++) idle(1, $sformatf("t5_busy%0d", k));
    step(V(0,0,0,0, 1,6, 1,6, 0, 0, 0, 0), "t5_rd6");

    // Test 6: reset mid-sweep restarts the full sweep
    step(V(0,1,7,8'h99, 0,0, 0,0, 0, 0, -1, -1), "t6_wr99");
    step(V(0,0,0,0, 1,7, 0,0, 0, 0, 8'h99, -1), "t6_rd99");
    step(V(0,0,0,0, 0,0, 0,0, 1, 0, -1, -1), "t6_clr");
    for (int k = 0; k < 5; k++) idle(1, $sformatf("t6_busy%0d", k));
    step(V(1,0,0,0, 0,0, 0,0, 0, 1, 0, 0), "t6_rst");
    for (int k = 0; k < 8; k++) idle(1, $sformatf("t6_sweep%0d", k));
    step(V(0,0,0,0, 1,7, 1,7, 0, 0, 0, 0), "t6_rd7");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ram_1w2r_clr.md
Name: ram_1w2r_clr

Overview:
Valid/tag-side memory for the caches with one write port and two independent read ports, e.g. a fetch-side lookup plus a snoop/refill-side lookup.
Built from two identical 1-write/1-read block-RAM banks that are written in lockstep, so each read port owns one bank.
Block RAM cannot be reset, so the block contains a clear sequencer that zeroes every word after reset or on request.

Parameters:
WIDTH, 8, data bits per word
DEEPTH, 1, address width; word count = 2^DEEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
W_addr  in  DEEPTH  write address
W_data  in  WIDTH  write data
W_en  in  1  write request
R_addr_A  in  DEEPTH  read port A address
R_en_A  in  1  read port A request
R_data_A  out  WIDTH  read port A data
R_addr_B  in  DEEPTH  read port B address
R_en_B  in  1  read port B request
R_data_B  out  WIDTH  read port B data
clr_req  in  1  single-cycle pulse: zero the whole memory
busy  out  1  clear sweep in progress; writes are dropped

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- FSM has two states, CLEAR and READY, and a DEEPTH-bit sweep pointer ptr.
- rst=1 on a clock edge:
  - state<=CLEAR, ptr<=0, busy=1.
  - R_data_A and R_data_B <= 0.
  - Pending read and forward state is discarded.
- CLEAR:
  - Each cycle writes 0 to ptr in both banks, then ptr<=ptr+1.
  - When ptr = 2^DEEPTH-1, that word is written and state<=READY.
  - busy falls exactly 2^DEEPTH cycles after the first cycle with rst=0.
  - rst asserted mid-sweep restarts the sweep from 0.
- READY with clr_req=1: state<=CLEAR, ptr<=0, busy=1 next cycle. Any W_en in that same cycle is dropped; clear wins.
- clr_req while busy is ignored; the sweep is not restarted or extended.
- W_en while busy is dropped silently; W_en in READY writes W_data to W_addr in both banks at the edge.
- Reads:
  - Latency 1: request sampled at edge N, data visible on R_data_X after edge N, valid through cycle N+1.
  - R_data_X holds its last value until the next enabled read on that port.
- Write-first forwarding:
  - Trigger: in READY, W_en and R_en_X in the same cycle with W_addr == R_addr_X.
  - Effect: R_data_X next cycle = W_data, not the old bank content.
  - Each port forwards independently; both may forward the same write.
- Reads during busy are accepted and return 0, because all contents are logically invalid.
- Read on the edge where the sweep completes: returns 0. A read in the following READY cycle returns the bank content, which is 0 unless written since.
- Both ports reading the same address return identical data.
- No read-after-write hazard beyond the same-cycle case: bank writes land at the edge, and a read issued one cycle later sees the new data.
- Address is exactly DEEPTH bits; no out-of-range case exists. ptr wraps naturally but the FSM leaves CLEAR before any reuse.
- Contents have no initial blocks; correctness relies on the post-reset sweep. The bench must not read before busy falls and expect anything other than 0.

Decomposition:
- Shared package (cache_pkg): state encodings ST_CLEAR and ST_READY.
- Sub-module ram_1w1r: one bank with a registered read and no reset on the array, to infer block RAM. Instantiated twice; the bank's write port is muxed between sweep (addr=ptr, data=0) and external write.
- The FSM, forward compare and output registers live in the top module.

Test Plan:
(WIDTH=8, DEEPTH=3, 8 words)
1. rst high 2 cycles then low → busy=1 for exactly 8 cycles then 0; R_data_A=R_data_B=0x00 during reset. A read of addr 5 on A and B after busy falls → 0x00.
2. Write 0x3C @2, next cycle R_en_A and R_en_B @2 → both outputs 0x3C one cycle later. Then idle 3 cycles with R_en low → outputs hold 0x3C.
3. Same cycle: write 0x55 @4, read A @4, read B @3 (3 holds 0x11) → R_data_A=0x55, R_data_B=0x11 next cycle.
4. Fill words 0..7 with 0xA0+i, pulse clr_req:
   - busy high 8 cycles; write 0xFF @1 during busy is dropped.
   - A second clr_req at busy cycle 4 does not extend busy.
   - Afterwards reads of @1 and @7 → 0x00.
5. Write 0x77 @6 in the same cycle as clr_req → after sweep, read @6 → 0x00, busy rises next cycle.
6. rst pulsed at sweep cycle 5 → busy stays high and falls 8 cycles after rst deasserts; reads then return 0x00.
